load_store_unit: RTL
====================

# load_store_unit

CPU-side initiator for the byte-addressed data memory. It accepts one load or store request at a time from the execute stage and issues the matching read or write on the memory port. For loads it captures the returned word and formats it: big-endian byte or halfword extraction, sign or zero extension, and the lwl/lwr merge. It returns a single-cycle response with data or an alignment/range error.

## Interface
- ADDR_BITS, 16, implemented memory address width; addresses with any bit set at or above ADDR_BITS are out of range.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE.
- req_op  input  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; any other value is an illegal op.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, or current rt value for the LWL/LWR merge.
- resp_valid  output  1  one-cycle response pulse.
- resp_data  output  32  formatted load result; 0 for stores and errors.
- resp_error  output  1  misaligned, out-of-range or illegal op; qualified by resp_valid.
- mem_address  output  32  memory address.
- mem_data  output  32  store data; byte in [7:0], halfword in [15:0].
- mem_readMode  output  2  0 NONE, 1 BYTE, 2 HALFWORD, 3 WORD.
- mem_writeMode  output  2  same encoding as mem_readMode.
- mem_dataOutput  input  32  read word, valid the cycle after the read is driven.

## Operation
- Handshake: a request is accepted on a rising edge when req_valid and req_ready are both high. Op, addr and wdata are registered at acceptance.
- Error check at acceptance:
  - halfword ops with addr[0]=1 are errors;
  - LW/SW with addr[1:0]≠0 are errors;
  - any addr bit ≥ ADDR_BITS set is an error;
  - an illegal op is an error.
  - LB/LBU/SB/LWL/LWR have no alignment restriction.
- States:
  - IDLE: accepted error → RESP; accepted load → RD; accepted store → WR.
  - RD: drive mem_readMode=WORD and mem_address={addr[31:2],2'b00} for exactly this cycle → WT.
  - WT: sample mem_dataOutput as W, register the formatted result → RESP.
  - WR: drive mem_writeMode (SB→1, SH→2, SW→3), mem_address=addr and mem_data=wdata for exactly this cycle → RESP.
  - RESP: resp_valid=1 → IDLE.
- Load formatting: k=addr[1:0]. Big-endian: the byte at offset k is W[31-8k -: 8], and the halfword at offset k is W[31-8k -: 16].
  - LB/LH: sign-extend the selected byte or halfword.
  - LBU/LHU: zero-extend it.
  - LW: W.
  - LWL: (W << 8k) | (wdata & ((1<<8k)-1)).
  - LWR: with s=8(3-k), (W >> s) | (wdata & ~(32'hFFFFFFFF >> s)).
- Shifts are 32-bit logical and truncated to 32 bits.
- Memory-port outputs are NONE/0 in every state except RD/WR.
- No request queueing; req_ready stays low from acceptance through RESP.

## Timing
- All outputs are registered. req_ready is decoded from state and is high in IDLE.
- Reset values:
  - state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_error=0;
  - mem_address=0, mem_data=0, mem_readMode=0, mem_writeMode=0.
- Latency from the acceptance edge (cycle 0):
  - load: RD in cycle 1, WT in cycle 2, resp_valid in cycle 3;
  - store: WR in cycle 1, resp_valid in cycle 2;
  - error: resp_valid in cycle 1, with no memory-port activity.
- Next acceptance is possible at the earliest on the edge ending the cycle after RESP (IDLE).
- resp_valid is never asserted for two consecutive cycles. It has no backpressure; the consumer must take it.
- Reset asserted in any state forces all outputs to reset values immediately. In WR, mem_writeMode drops asynchronously, so no write is committed. No response is ever produced for an interrupted request.
- req_valid held high through RESP is not accepted until IDLE.

## Test plan
- Memory word at 0x100 = 0x8899AABB.
  - LB 0x101 → resp_data=0xFFFFFF99 in cycle 3.
  - LBU 0x101 → 0x00000099.
  - LW 0x100 → 0x8899AABB, with mem_readMode=3 and mem_address=0x100 only in cycle 1.
- Same word:
  - LH 0x102 → 0xFFFFAABB.
  - LHU 0x102 → 0x0000AABB.
  - LH 0x101 → resp_error=1 and resp_data=0 in cycle 1, mem_readMode never non-zero.
- Same word with wdata=0x11223344:
  - LWL 0x101 → 0x99AABB44.
  - LWR 0x101 → 0x11228899.
  - LWL 0x100 → 0x8899AABB.
  - LWR 0x103 → 0x8899AABB.
- SB 0x103, wdata=0x12345677 → cycle 1: mem_writeMode=1, mem_address=0x103, mem_data=0x12345677. Cycle 2: resp_valid=1, resp_data=0, resp_error=0.
- LW 0x00010000, SW 0x102 and op 7 → each returns resp_error=1 in cycle 1 with no memory activity.
- Reset pulsed low during WT of an LW, then a request issued after release → no resp_valid for the interrupted LW, and all outputs at reset values during reset. Next LBU 0x100 after release returns 0x00000088 in cycle 3.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store initiator for the byte-addressed
// data memory. Issues one word read or one sized write per request, formats load
// data (big-endian byte/halfword extract, sign/zero extend, lwl/lwr merge) and
// returns a one-cycle response carrying either the result or an error flag.
module load_store_unit #(
  parameter int ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data,
  output logic [1:0]  mem_readMode,
  output logic [1:0]  mem_writeMode,
  input  logic [31:0] mem_dataOutput
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  state_t state_q, state_d;

  // Request fields captured at acceptance; only meaningful while busy, so unreset.
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [1:0]  mem_read_mode_q, mem_read_mode_d;
  logic [1:0]  mem_write_mode_q, mem_write_mode_d;

  logic        accept;
  logic        is_load;
  logic        is_store;
  logic        req_err;

  logic [1:0]  k;
  logic [31:0] w_shl;
  logic [31:0] w_shr;
  logic [31:0] lwl_mask;
  logic [31:0] lwr_mask;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_result;

  // Classify the incoming request and detect alignment/range/op errors.
  always_comb begin
    accept   = req_valid && (state_q == S_IDLE);
    is_load  = (req_op <= OP_LWR);
    is_store = (req_op == OP_SB) || (req_op == OP_SH) || (req_op == OP_SW);
    req_err  = 1'b0;
    if (!is_load && !is_store) req_err = 1'b1;
    if (((req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH)) && req_addr[0])
      req_err = 1'b1;
    if (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00))
      req_err = 1'b1;
    if ((req_addr >> ADDR_BITS) != 32'd0) req_err = 1'b1;
  end

  // Big-endian load formatting of the returned word (offset k = addr[1:0]).
  always_comb begin
    k        = addr_q[1:0];
    // Left-shifting by 8k brings byte/halfword at offset k to the top of the word.
    w_shl    = mem_dataOutput << {k, 3'b000};
    // Right shift by 8*(3-k); {~k,000} equals 24-8k.
    w_shr    = mem_dataOutput >> {~k, 3'b000};
    lwl_mask = ~(32'hFFFF_FFFF << {k, 3'b000});
    lwr_mask = ~(32'hFFFF_FFFF >> {~k, 3'b000});
    sel_byte = w_shl[31:24];
    sel_half = w_shl[31:16];
    case (op_q)
      OP_LB:   load_result = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_result = {24'd0, sel_byte};
      OP_LH:   load_result = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_result = {16'd0, sel_half};
      OP_LW:   load_result = mem_dataOutput;
      OP_LWL:  load_result = w_shl | (wdata_q & lwl_mask);
      OP_LWR:  load_result = w_shr | (wdata_q & lwr_mask);
      default: load_result = 32'd0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)      state_d = S_RESP;
          else if (is_load) state_d = S_RD;
          else              state_d = S_WR;
        end
      end
      S_RD:    state_d = S_WT;
      S_WT:    state_d = S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: values for the registered outputs in the cycle after this edge.
  always_comb begin
    resp_valid_d     = 1'b0;
    resp_data_d      = 32'd0;
    resp_error_d     = 1'b0;
    mem_address_d    = 32'd0;
    mem_data_d       = 32'd0;
    mem_read_mode_d  = 2'd0;
    mem_write_mode_d = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (is_load) begin
            mem_read_mode_d = 2'd3;
            mem_address_d   = {req_addr[31:2], 2'b00};
          end else begin
            // SB/SH/SW encode as 8/9/10, so the low bits plus one give the size.
            mem_write_mode_d = req_op[1:0] + 2'd1;
            mem_address_d    = req_addr;
            mem_data_d       = req_wdata;
          end
        end
      end
      S_WT: begin
        resp_valid_d = 1'b1;
        resp_data_d  = load_result;
      end
      S_WR: begin
        resp_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs, cleared asynchronously so an in-flight write is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_q     <= 1'b0;
      resp_data_q      <= 32'd0;
      resp_error_q     <= 1'b0;
      mem_address_q    <= 32'd0;
      mem_data_q       <= 32'd0;
      mem_read_mode_q  <= 2'd0;
      mem_write_mode_q <= 2'd0;
    end else begin
      resp_valid_q     <= resp_valid_d;
      resp_data_q      <= resp_data_d;
      resp_error_q     <= resp_error_d;
      mem_address_q    <= mem_address_d;
      mem_data_q       <= mem_data_d;
      mem_read_mode_q  <= mem_read_mode_d;
      mem_write_mode_q <= mem_write_mode_d;
    end
  end

  // Capture the request fields at acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= req_op;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_error    = resp_error_q;
  assign mem_address   = mem_address_q;
  assign mem_data      = mem_data_q;
  assign mem_readMode  = mem_read_mode_q;
  assign mem_writeMode = mem_write_mode_q;

endmodule
